// File: rtl/lifo_stack.sv
// Synchronous LIFO stack: one push or pop per triggered cycle.
// Registered read data and a one-cycle completion pulse.
module lifo_stack #(
  parameter int STACKDATA = 32,
  parameter int STACKSIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 trigger,
  input  logic [STACKDATA-1:0] write_value,
  output logic [STACKDATA-1:0] read_value,
  output logic                 done_out
);

  localparam int AW  = $clog2(STACKSIZE);
  localparam int SPW = AW + 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACKSIZE);
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);

  logic [STACKDATA-1:0] mem_q [STACKSIZE];
  logic [SPW-1:0]       sp_q, sp_d;
  logic [SPW-1:0]       sp_m1;
  logic [STACKDATA-1:0] rd_q, rd_d;
  logic                 done_q, done_d;
  logic                 full, empty;
  logic                 do_push, do_pop;

  assign full    = (sp_q == SP_FULL);
  assign empty   = (sp_q == '0);
  assign sp_m1   = sp_q - SP_ONE;
  assign do_push = trigger & push & ~full;
  assign do_pop  = trigger & ~push & ~empty;

  // Next-state: pointer moves only on accepted commands; done pulses on any trigger.
  always_comb begin
    sp_d   = sp_q;
    rd_d   = rd_q;
    done_d = trigger;
    if (do_push) begin
      sp_d = sp_q + SP_ONE;
    end else if (do_pop) begin
      sp_d = sp_m1;
      rd_d = mem_q[sp_m1[AW-1:0]];
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q   <= '0;
      rd_q   <= '0;
      done_q <= 1'b0;
    end else begin
      sp_q   <= sp_d;
      rd_q   <= rd_d;
      done_q <= done_d;
    end
  end

  // Storage array: written on accepted push; reset drops the command.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem_q[sp_q[AW-1:0]] <= write_value;
    end
  end

  assign read_value = rd_q;
  assign done_out   = done_q;

endmodule

// File: tb/tb_lifo_stack.sv
// Testbench for lifo_stack: directed scenarios plus random
// traffic checked against a queue-based reference stack.
module tb_lifo_stack;

  localparam int DW = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          push;
  logic          trigger;
  logic [DW-1:0] write_value;
  logic [DW-1:0] read_value;
  logic          done_out;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] model_q [$];
  logic [DW-1:0] exp_rd;
  logic          exp_done;

  lifo_stack #(.STACKDATA(DW), .STACKSIZE(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .trigger    (trigger),
    .write_value(write_value),
    .read_value (read_value),
    .done_out   (done_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, update the model, check after the posedge.
  task automatic step(input logic r, input logic t, input logic p,
                      input logic [DW-1:0] v, input string tag);
    @(negedge clk);
    rst = r;
    trigger = t;
    push = p;
    write_value = v;
    @(posedge clk);
    #1;
    if (r) begin
      model_q.delete();
      exp_rd = '0;
      exp_done = 1'b0;
    end else begin
      exp_done = t;
      if (t && p && model_q.size() < DEPTH) model_q.push_back(v);
      else if (t && !p && model_q.size() > 0) exp_rd = model_q.pop_back();
    end
    chk({tag, ".rd"}, read_value, exp_rd);
    chk({tag, ".done"}, {31'b0, done_out}, {31'b0, exp_done});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, "idle");
  endtask

  task automatic cmd(input logic p, input logic [DW-1:0] v, input string tag);
    step(1'b0, 1'b1, p, v, tag);
    idle(10);
  endtask

  initial begin
    rst = 1'b1;
    trigger = 1'b0;
    push = 1'b0;
    write_value = '0;
    exp_rd = '0;
    exp_done = 1'b0;

    step(1'b1, 1'b0, 1'b0, '0, "reset");
    step(1'b1, 1'b0, 1'b0, '0, "reset");
    chk("reset_rd_zero", read_value, 32'h0);
    cmd(1'b0, '0, "empty_pop");

    cmd(1'b1, 32'hcafebabe, "push1");
    cmd(1'b0, '0, "pop1");
    chk("pop1_value", read_value, 32'hcafebabe);

    cmd(1'b1, 32'hdeadbeef, "push2a");
    cmd(1'b1, 32'hb105f00d, "push2b");
    cmd(1'b0, '0, "pop2a");
    cmd(1'b0, '0, "pop2b");

    for (int i = 0; i < DEPTH; i++) cmd(1'b1, DW'(i), "fill");
    cmd(1'b1, 32'h0bad0bad, "push_full");
    for (int i = 0; i < DEPTH; i++) cmd(1'b0, '0, "drain");
    cmd(1'b0, '0, "pop_empty");
    chk("pop_empty_hold", read_value, 32'h0);

    for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 1'b1, DW'(i), "b2b_push");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0, "b2b_pop");
    idle(10);

    cmd(1'b1, 32'h12345678, "pre_rst_push");
    step(1'b1, 1'b1, 1'b0, '0, "rst_with_pop");
    idle(10);
    cmd(1'b0, '0, "post_rst_pop");
    chk("post_rst_rd", read_value, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      logic r, t, p;
      int bias;
      bias = ((i / 150) % 2 == 0) ? 8 : 2;
      r = ($urandom_range(0, 199) == 0);
      t = ($urandom_range(0, 3) != 0);
      p = ($urandom_range(0, 9) < bias);
      step(r, t, p, $urandom, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
